sram_window_raster: RTL and testbench

Parametrised address generator that walks a rectangular window of the SRAM frame buffer and emits one (x, y) coordinate per accepted beat. It replaces the fixed 11-bit, unit-step, free-running window scanner. It adds a configurable stride, raster or serpentine order, a valid/ready output handshake, abort, window-error detection, and frame/line markers. It sits between the window-request logic and the SRAM read-address port.

---
 rtl/sram_scan_pkg.sv | 40 ++++
 rtl/scan_axis_step.sv | 33 +++
 rtl/sram_window_raster.sv | 147 ++++++++++++++
 tb/tb_sram_window_raster.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_scan_pkg.sv
// Shared types and defaults for the SRAM window scanner.
// Window packing keeps x0 in the MSBs, y1 in the LSBs.
package sram_scan_pkg;

    localparam int DEF_COORD_W = 11;
    localparam int DEF_STEP_W  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic RASTER     = 1'b0;
    localparam logic SERPENTINE = 1'b1;

    typedef struct packed {
        logic [DEF_COORD_W-1:0] x0;
        logic [DEF_COORD_W-1:0] y0;
        logic [DEF_COORD_W-1:0] x1;
        logic [DEF_COORD_W-1:0] y1;
    } win_t;

    function automatic logic [4*DEF_COORD_W-1:0] win_pack(
        input win_t w
    );
        return {w.x0, w.y0, w.x1, w.y1};
    endfunction

    function automatic win_t win_unpack(
        input logic [4*DEF_COORD_W-1:0] v
    );
        win_t w;
        w.x0 = v[4*DEF_COORD_W-1:3*DEF_COORD_W];
        w.y0 = v[3*DEF_COORD_W-1:2*DEF_COORD_W];
        w.x1 = v[2*DEF_COORD_W-1:DEF_COORD_W];
        w.y1 = v[DEF_COORD_W-1:0];
        return w;
    endfunction

endpackage

// File: rtl/scan_axis_step.sv
// One-axis stride step with bound test in W+1 bits.
// dir=0 steps up against an upper bound, dir=1 steps down against a lower bound.
module scan_axis_step
    import sram_scan_pkg::*;
#(
    parameter int W  = DEF_COORD_W,
    parameter int SW = DEF_STEP_W
) (
    input  logic [W-1:0]  coord,
    input  logic [SW-1:0] stride,
    input  logic [W-1:0]  bound,
    input  logic          dir,
    output logic [W-1:0]  nxt,
    output logic          ovf
);

    logic [W:0] fwd;
    logic [W:0] bwd;

    always_comb begin
        fwd = {1'b0, coord} + (W+1)'(stride);
        bwd = {1'b0, coord} - (W+1)'(stride);
        if (dir) begin
            nxt = bwd[W-1:0];
            // MSB set means the subtraction went below zero
            ovf = bwd[W] || (bwd[W-1:0] < bound);
        end else begin
            nxt = fwd[W-1:0];
            ovf = fwd > {1'b0, bound};
        end
    end

endmodule

// File: rtl/sram_window_raster.sv
// Strided raster/serpentine window walker feeding the SRAM read address.
// One (x, y) beat per valid/ready transfer; done/err are one-cycle pulses.
module sram_window_raster
    import sram_scan_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W,
    parameter int STEP_W  = DEF_STEP_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*COORD_W-1:0] window,
    input  logic [STEP_W-1:0]    step_x,
    input  logic [STEP_W-1:0]    step_y,
    input  logic                 mode,
    input  logic                 abort,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [COORD_W-1:0]   x,
    output logic [COORD_W-1:0]   y,
    output logic                 line_last,
    output logic                 frame_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    state_t state_q;
    state_t state_d;

    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [STEP_W-1:0]  sx_q, sy_q;
    logic               mode_q;
    logic               rev_q;

    logic [COORD_W-1:0] wx0, wy0, wx1, wy1;
    logic               bad;
    logic               req;
    logic               fire;

    logic [COORD_W-1:0] x_nxt, y_nxt;
    logic               x_ovf, y_ovf;
    logic [COORD_W-1:0] x_bound;

    assign wx0 = window[4*COORD_W-1:3*COORD_W];
    assign wy0 = window[3*COORD_W-1:2*COORD_W];
    assign wx1 = window[2*COORD_W-1:COORD_W];
    assign wy1 = window[COORD_W-1:0];

    assign bad  = (wx1 < wx0) || (wy1 < wy0);
    assign req  = (state_q == IDLE) && start && !abort;
    assign fire = (state_q == SCAN) && out_ready;

    // Reverse lines stop at x0, forward lines at x1
    assign x_bound = rev_q ? x0_q : x1_q;

    scan_axis_step #(.W(COORD_W), .SW(STEP_W)) u_xstep (
        .coord  (x),
        .stride (sx_q),
        .bound  (x_bound),
        .dir    (rev_q),
        .nxt    (x_nxt),
        .ovf    (x_ovf)
    );

    scan_axis_step #(.W(COORD_W), .SW(STEP_W)) u_ystep (
        .coord  (y),
        .stride (sy_q),
        .bound  (y1_q),
        .dir    (1'b0),
        .nxt    (y_nxt),
        .ovf    (y_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req && !bad) state_d = SCAN;
            SCAN: begin
                if (abort || (fire && x_ovf && y_ovf))
                    state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_valid  = (state_q == SCAN);
        busy       = (state_q == SCAN);
        line_last  = out_valid && x_ovf;
        frame_last = out_valid && x_ovf && y_ovf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q   <= '0;
            y0_q   <= '0;
            x1_q   <= '0;
            y1_q   <= '0;
            sx_q   <= '0;
            sy_q   <= '0;
            mode_q <= RASTER;
            rev_q  <= 1'b0;
            x      <= '0;
            y      <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (req && bad) begin
                err <= 1'b1;
            end else if (req) begin
                x0_q   <= wx0;
                y0_q   <= wy0;
                x1_q   <= wx1;
                y1_q   <= wy1;
                sx_q   <= (step_x == '0) ? STEP_W'(1) : step_x;
                sy_q   <= (step_y == '0) ? STEP_W'(1) : step_y;
                mode_q <= mode;
                rev_q  <= 1'b0;
                x      <= wx0;
                y      <= wy0;
            end else if (fire && !abort) begin
                if (!x_ovf) begin
                    x <= x_nxt;
                end else if (y_ovf) begin
                    done <= 1'b1;
                end else begin
                    y <= y_nxt;
                    if (mode_q == SERPENTINE) begin
                        rev_q <= !rev_q;
                        // A line turning forward restarts at x0; a reverse one keeps x
                        if (rev_q) x <= x0_q;
                    end else begin
                        x <= x0_q;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_window_raster.sv
// Scoreboard bench for sram_window_raster: directed scans, monitor pops beats.
// Covers raster, serpentine, top edge, backpressure, err, abort and reset.
module tb_sram_window_raster;
    import sram_scan_pkg::*;

    localparam int CW = DEF_COORD_W;
    localparam int SW = DEF_STEP_W;

    typedef struct {
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ll;
        logic          fl;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [4*CW-1:0] window;
    logic [SW-1:0] step_x;
    logic [SW-1:0] step_y;
    logic          mode;
    logic          abort;
    logic          out_ready;
    logic          out_valid;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_last;
    logic          frame_last;
    logic          busy;
    logic          done;
    logic          err;

    beat_t q[$];
    int    nvec = 0;
    int    nmis = 0;

    logic                stall = 1'b0;
    logic [2*CW+1:0]     held;

    sram_window_raster #(.COORD_W(CW), .STEP_W(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .window     (window),
        .step_x     (step_x),
        .step_y     (step_y),
        .mode       (mode),
        .abort      (abort),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .x          (x),
        .y          (y),
        .line_last  (line_last),
        .frame_last (frame_last),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int px, input int py, input bit ll, input bit fl);
        beat_t b;
        b.x  = CW'(px);
        b.y  = CW'(py);
        b.ll = ll;
        b.fl = fl;
        q.push_back(b);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (out_valid && stall)
                check("hold", 64'({x, y, line_last, frame_last}), 64'(held));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL beat_extra: got (%0d,%0d), required none", x, y);
                end else begin
                    beat_t e;
                    e = q.pop_front();
                    check("beat", 64'({x, y, line_last, frame_last}),
                          64'({e.x, e.y, e.ll, e.fl}));
                end
            end
            stall = out_valid && !out_ready;
            held  = {x, y, line_last, frame_last};
        end
    end

    task automatic kick(input int x0, input int y0, input int x1, input int y1,
                        input int sx, input int sy, input logic m,
                        input logic rdy);
        win_t w;
        @(posedge clk);
        #1;
        w.x0      = CW'(x0);
        w.y0      = CW'(y0);
        w.x1      = CW'(x1);
        w.y1      = CW'(y1);
        window    = win_pack(w);
        step_x    = SW'(sx);
        step_y    = SW'(sy);
        mode      = m;
        out_ready = rdy;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input logic [3:0] pat);
        bit got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            out_ready = pat[k % 4];
            @(negedge clk);
            if (done) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("done_seen", 64'(got), 64'd1);
        if (got) begin
            check("q_empty_at_done", 64'(q.size()), 64'd0);
            check("idle_at_done", 64'({out_valid, busy}), 64'd0);
            @(negedge clk);
            check("done_one_cycle", 64'(done), 64'd0);
        end
        q.delete();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        window    = '0;
        step_x    = '0;
        step_y    = '0;
        mode      = RASTER;
        abort     = 1'b0;
        out_ready = 1'b1;
        #12;
        check("reset_outs", 64'({out_valid, x, y, line_last, frame_last,
                                 busy, done, err}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // raster 4x2, unit stride
        push(2, 3, 0, 0); push(3, 3, 0, 0); push(4, 3, 0, 0); push(5, 3, 1, 0);
        push(2, 4, 0, 0); push(3, 4, 0, 0); push(4, 4, 0, 0); push(5, 4, 1, 1);
        kick(2, 3, 5, 4, 1, 1, RASTER, 1'b1);
        check("first_beat_valid", 64'({out_valid, busy, x, y}),
              64'({1'b1, 1'b1, 11'd2, 11'd3}));
        wait_done(4'b1111);

        // serpentine, stride 2
        push(0, 0, 0, 0); push(2, 0, 0, 0); push(4, 0, 0, 0); push(6, 0, 1, 0);
        push(6, 2, 0, 0); push(4, 2, 0, 0); push(2, 2, 0, 0); push(0, 2, 1, 1);
        kick(0, 0, 6, 2, 2, 2, SERPENTINE, 1'b1);
        wait_done(4'b1111);

        // top edge of the coordinate range: no wrap
        push(2045, 0, 0, 0); push(2047, 0, 1, 1);
        kick(2045, 0, 2047, 0, 2, 1, RASTER, 1'b1);
        wait_done(4'b1111);

        // stride 0 behaves as 1
        push(7, 9, 0, 0); push(8, 9, 1, 0); push(7, 10, 0, 0); push(8, 10, 1, 1);
        kick(7, 9, 8, 10, 0, 0, RASTER, 1'b1);
        wait_done(4'b1111);

        // backpressure 1,0,0,1
        push(0, 0, 0, 0); push(1, 0, 0, 0); push(2, 0, 1, 0);
        push(0, 1, 0, 0); push(1, 1, 0, 0); push(2, 1, 1, 1);
        kick(0, 0, 2, 1, 1, 1, RASTER, 1'b1);
        wait_done(4'b1001);

        // rejected window
        kick(5, 0, 4, 3, 1, 1, RASTER, 1'b1);
        @(negedge clk);
        check("err_pulse", 64'({err, busy, out_valid}), 64'({1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        check("err_one_cycle", 64'({err, busy, out_valid}), 64'd0);

        // start together with abort in IDLE is dropped
        abort = 1'b1;
        kick(0, 0, 3, 3, 1, 1, RASTER, 1'b1);
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_dropped", 64'({busy, out_valid, err}), 64'd0);

        // abort after three beats
        push(2, 3, 0, 0); push(3, 3, 0, 0); push(4, 3, 0, 0);
        kick(2, 3, 5, 4, 1, 1, RASTER, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        abort     = 1'b1;
        @(posedge clk);
        #1;
        abort     = 1'b0;
        out_ready = 1'b1;
        check("abort_idle", 64'({out_valid, busy}), 64'd0);
        check("abort_beats_taken", 64'(q.size()), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'({done, busy}), 64'd0);
        end
        q.delete();

        // fresh scan after abort
        push(2, 3, 0, 0); push(3, 3, 0, 0); push(4, 3, 0, 0); push(5, 3, 1, 0);
        push(2, 4, 0, 0); push(3, 4, 0, 0); push(4, 4, 0, 0); push(5, 4, 1, 1);
        kick(2, 3, 5, 4, 1, 1, RASTER, 1'b1);
        wait_done(4'b1111);

        // asynchronous reset mid-scan
        push(2, 3, 0, 0); push(3, 3, 0, 0);
        kick(2, 3, 5, 4, 1, 1, RASTER, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outs", 64'({out_valid, x, y, line_last, frame_last,
                                   busy, done, err}), 64'd0);
        check("rst_beats_taken", 64'(q.size()), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_resume", 64'({out_valid, busy, done, x, y}), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
